// File: rtl/tug_arbiter.sv
// tug_arbiter: two-key tug-of-war light game; a lone press pulls the light one step,
// pulling past either end wins the round, and SCORE_MAX round wins end the match.
module tug_arbiter #(
   parameter int POSITIONS   = 9,
   parameter int SCORE_MAX   = 7,
   parameter int HOLD_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 key_l,
   input  logic                 key_r,
   output logic [POSITIONS-1:0] led,
   output logic [2:0]           score_l,
   output logic [2:0]           score_r,
   output logic [1:0]           winner,
   output logic                 match_over
);
   localparam int PW = $clog2(POSITIONS);
   localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [PW-1:0] P_TOP = PW'(POSITIONS - 1);
   localparam logic [PW-1:0] P_C = PW'((POSITIONS - 1) / 2);
   localparam logic [HW-1:0] H_LOAD = HW'(HOLD_CYCLES - 1);
   localparam logic [2:0] S_MAX = 3'(SCORE_MAX);

   typedef enum logic [1:0] {PLAY, WIN_L, WIN_R, MATCH_END} state_t;

   state_t        state, nxt_state;
   logic [PW-1:0] pos, nxt_pos;
   logic [HW-1:0] hold, nxt_hold;
   logic [2:0]    nxt_score_l, nxt_score_r;
   logic [1:0]    nxt_winner;
   logic          prev_l, prev_r, press_l, press_r, move_l, move_r;

   assign press_l = key_l & ~prev_l;
   assign press_r = key_r & ~prev_r;
   assign move_l  = press_l & ~press_r;
   assign move_r  = press_r & ~press_l;

   // prev flops reset high so keys held through reset release are not presses
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state      <= PLAY;
         pos        <= P_C;
         led        <= POSITIONS'(1) << P_C;
         hold       <= '0;
         score_l    <= '0;
         score_r    <= '0;
         winner     <= 2'b00;
         match_over <= 1'b0;
         prev_l     <= 1'b1;
         prev_r     <= 1'b1;
      end else begin
         state      <= nxt_state;
         pos        <= nxt_pos;
         led        <= POSITIONS'(1) << nxt_pos;
         hold       <= nxt_hold;
         score_l    <= nxt_score_l;
         score_r    <= nxt_score_r;
         winner     <= nxt_winner;
         match_over <= nxt_state == MATCH_END;
         prev_l     <= key_l;
         prev_r     <= key_r;
      end

   always_comb begin
      nxt_state = state;
      case (state)
         PLAY:    nxt_state = move_l && pos == P_TOP ? WIN_L : move_r && pos == '0 ? WIN_R : PLAY;
         WIN_L:   nxt_state = hold != '0 ? WIN_L : score_l == S_MAX ? MATCH_END : PLAY;
         WIN_R:   nxt_state = hold != '0 ? WIN_R : score_r == S_MAX ? MATCH_END : PLAY;
         default: nxt_state = MATCH_END;
      endcase
   end

   always_comb begin
      nxt_pos     = pos;
      nxt_hold    = hold;
      nxt_score_l = score_l;
      nxt_score_r = score_r;
      nxt_winner  = winner;
      if (state == PLAY && move_l && pos != P_TOP) nxt_pos = pos + 1'b1;
      if (state == PLAY && move_r && pos != '0) nxt_pos = pos - 1'b1;
      if (state == PLAY && nxt_state == WIN_L) begin
         nxt_score_l = score_l + {2'b00, score_l != S_MAX};
         nxt_winner  = 2'b10;
         nxt_hold    = H_LOAD;
      end
      if (state == PLAY && nxt_state == WIN_R) begin
         nxt_score_r = score_r + {2'b00, score_r != S_MAX};
         nxt_winner  = 2'b01;
         nxt_hold    = H_LOAD;
      end
      if ((state == WIN_L || state == WIN_R) && hold != '0) nxt_hold = hold - 1'b1;
      if (state != PLAY && nxt_state == PLAY) begin
         nxt_pos    = P_C;
         nxt_winner = 2'b00;
      end
   end
endmodule

// File: tb/tb_tug_arbiter.sv
// tb_tug_arbiter: scoreboard bench; expected output words are queued as stimulus is
// driven and popped against the DUT one cycle later (or immediately for async reset).
module tb_tug_arbiter;
   logic clk = 1'b0, reset = 1'b1, key_l = 1'b0, key_r = 1'b0;
   logic [8:0] led0, led1;
   logic [2:0] sl0, sr0, sl1, sr1;
   logic [1:0] w0, w1;
   logic mo0, mo1;
   logic [17:0] q[$];
   logic [17:0] e;
   int compared = 0, mismatched = 0;

   always #5 clk = ~clk;

   tug_arbiter u0 (
      .clk(clk), .reset(reset), .key_l(key_l), .key_r(key_r),
      .led(led0), .score_l(sl0), .score_r(sr0), .winner(w0), .match_over(mo0)
   );

   tug_arbiter #(.SCORE_MAX(1)) u1 (
      .clk(clk), .reset(reset), .key_l(key_l), .key_r(key_r),
      .led(led1), .score_l(sl1), .score_r(sr1), .winner(w1), .match_over(mo1)
   );

   function automatic logic [17:0] ex(int p, int sl, int sr, int w, logic mo);
      logic [8:0] l;
      l = 9'd1 << p;
      return {l, 3'(sl), 3'(sr), 2'(w), mo};
   endfunction

   function automatic logic [17:0] obs(bit which);
      return which ? {led1, sl1, sr1, w1, mo1} : {led0, sl0, sr0, w0, mo0};
   endfunction

   task automatic tick(input logic kl, input logic kr);
      key_l = kl;
      key_r = kr;
      @(posedge clk);
      #1;
   endtask

   task automatic reset_on();
      #2 reset = 1'b1;
      #1;
   endtask

   task automatic reset_off();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      @(posedge clk);
      #1;
      q.push_back(ex(4, 0, 0, 0, 0));
      e = q.pop_front(); compared++;
      if (obs(0) !== e) begin mismatched++; $display("FAIL reset_held: got %h expected %h", obs(0), e); end
      reset_off();
      q.push_back(ex(4, 0, 0, 0, 0));
      e = q.pop_front(); compared++;
      if (obs(0) !== e) begin mismatched++; $display("FAIL reset_release: got %h expected %h", obs(0), e); end
   endtask

   task automatic test_step_left();
      for (int i = 0; i < 4; i++) begin
         q.push_back(ex(5 + i, 0, 0, 0, 0));
         tick(1'b1, 1'b0);
         e = q.pop_front(); compared++;
         if (obs(0) !== e) begin mismatched++; $display("FAIL step_left press %0d: got %h expected %h", i, obs(0), e); end
         q.push_back(ex(5 + i, 0, 0, 0, 0));
         tick(1'b0, 1'b0);
         e = q.pop_front(); compared++;
         if (obs(0) !== e) begin mismatched++; $display("FAIL step_left gap %0d: got %h expected %h", i, obs(0), e); end
      end
      reset_on();
      q.push_back(ex(4, 0, 0, 0, 0));
      e = q.pop_front(); compared++;
      if (obs(0) !== e) begin mismatched++; $display("FAIL async_reset_mid_round: got %h expected %h", obs(0), e); end
      reset_off();
   endtask

   task automatic test_both();
      q.push_back(ex(4, 0, 0, 0, 0));
      tick(1'b1, 1'b1);
      e = q.pop_front(); compared++;
      if (obs(0) !== e) begin mismatched++; $display("FAIL both_keys: got %h expected %h", obs(0), e); end
      q.push_back(ex(4, 0, 0, 0, 0));
      tick(1'b0, 1'b0);
      e = q.pop_front(); compared++;
      if (obs(0) !== e) begin mismatched++; $display("FAIL both_keys_release: got %h expected %h", obs(0), e); end
   endtask

   task automatic test_held_key();
      for (int i = 0; i < 10; i++) begin
         q.push_back(ex(3, 0, 0, 0, 0));
         tick(1'b0, 1'b1);
         e = q.pop_front(); compared++;
         if (obs(0) !== e) begin mismatched++; $display("FAIL held_right cycle %0d: got %h expected %h", i, obs(0), e); end
      end
      tick(1'b0, 1'b0);
      reset_on();
      reset_off();
   endtask

   task automatic test_win_right();
      for (int i = 0; i < 4; i++) begin
         q.push_back(ex(3 - i, 0, 0, 0, 0));
         tick(1'b0, 1'b1);
         e = q.pop_front(); compared++;
         if (obs(0) !== e) begin mismatched++; $display("FAIL win_right press %0d: got %h expected %h", i, obs(0), e); end
         tick(1'b0, 1'b0);
      end
      q.push_back(ex(0, 0, 1, 1, 0));
      tick(1'b0, 1'b1);
      e = q.pop_front(); compared++;
      if (obs(0) !== e) begin mismatched++; $display("FAIL win_right enter: got %h expected %h", obs(0), e); end
      for (int i = 0; i < 3; i++) begin
         q.push_back(ex(0, 0, 1, 1, 0));
         tick(i != 1, 1'b0);
         e = q.pop_front(); compared++;
         if (obs(0) !== e) begin mismatched++; $display("FAIL win_right hold %0d: got %h expected %h", i, obs(0), e); end
      end
      q.push_back(ex(4, 0, 1, 0, 0));
      tick(1'b1, 1'b0);
      e = q.pop_front(); compared++;
      if (obs(0) !== e) begin mismatched++; $display("FAIL win_right recenter: got %h expected %h", obs(0), e); end
      q.push_back(ex(4, 0, 1, 0, 0));
      tick(1'b1, 1'b0);
      e = q.pop_front(); compared++;
      if (obs(0) !== e) begin mismatched++; $display("FAIL win_right held_across: got %h expected %h", obs(0), e); end
      tick(1'b0, 1'b0);
      q.push_back(ex(5, 0, 1, 0, 0));
      tick(1'b1, 1'b0);
      e = q.pop_front(); compared++;
      if (obs(0) !== e) begin mismatched++; $display("FAIL win_right resume: got %h expected %h", obs(0), e); end
      tick(1'b0, 1'b0);
   endtask

   task automatic test_match_end();
      reset_on();
      reset_off();
      for (int i = 0; i < 4; i++) begin
         q.push_back(ex(5 + i, 0, 0, 0, 0));
         tick(1'b1, 1'b0);
         e = q.pop_front(); compared++;
         if (obs(1) !== e) begin mismatched++; $display("FAIL match press %0d: got %h expected %h", i, obs(1), e); end
         tick(1'b0, 1'b0);
      end
      q.push_back(ex(8, 1, 0, 2, 0));
      tick(1'b1, 1'b0);
      e = q.pop_front(); compared++;
      if (obs(1) !== e) begin mismatched++; $display("FAIL match win_left: got %h expected %h", obs(1), e); end
      for (int i = 0; i < 3; i++) begin
         q.push_back(ex(8, 1, 0, 2, 0));
         tick(1'b0, 1'b0);
         e = q.pop_front(); compared++;
         if (obs(1) !== e) begin mismatched++; $display("FAIL match hold %0d: got %h expected %h", i, obs(1), e); end
      end
      q.push_back(ex(8, 1, 0, 2, 1));
      tick(1'b0, 1'b0);
      e = q.pop_front(); compared++;
      if (obs(1) !== e) begin mismatched++; $display("FAIL match_over_set: got %h expected %h", obs(1), e); end
      for (int i = 0; i < 4; i++) begin
         q.push_back(ex(8, 1, 0, 2, 1));
         tick(i[0], ~i[0]);
         e = q.pop_front(); compared++;
         if (obs(1) !== e) begin mismatched++; $display("FAIL match frozen %0d: got %h expected %h", i, obs(1), e); end
      end
      key_l = 1'b0;
      key_r = 1'b0;
      reset_on();
      q.push_back(ex(4, 0, 0, 0, 0));
      e = q.pop_front(); compared++;
      if (obs(1) !== e) begin mismatched++; $display("FAIL match async_reset: got %h expected %h", obs(1), e); end
      reset_off();
      q.push_back(ex(4, 0, 0, 0, 0));
      e = q.pop_front(); compared++;
      if (obs(1) !== e) begin mismatched++; $display("FAIL match after_reset: got %h expected %h", obs(1), e); end
   endtask

   task automatic test_reset_held_key();
      q.push_back(ex(5, 0, 0, 0, 0));
      tick(1'b1, 1'b0);
      e = q.pop_front(); compared++;
      if (obs(0) !== e) begin mismatched++; $display("FAIL held_reset setup: got %h expected %h", obs(0), e); end
      reset_on();
      q.push_back(ex(4, 0, 0, 0, 0));
      e = q.pop_front(); compared++;
      if (obs(0) !== e) begin mismatched++; $display("FAIL held_reset async: got %h expected %h", obs(0), e); end
      reset_off();
      for (int i = 0; i < 2; i++) begin
         q.push_back(ex(4, 0, 0, 0, 0));
         tick(1'b1, 1'b0);
         e = q.pop_front(); compared++;
         if (obs(0) !== e) begin mismatched++; $display("FAIL held_reset no_press %0d: got %h expected %h", i, obs(0), e); end
      end
      tick(1'b0, 1'b0);
      q.push_back(ex(5, 0, 0, 0, 0));
      tick(1'b1, 1'b0);
      e = q.pop_front(); compared++;
      if (obs(0) !== e) begin mismatched++; $display("FAIL held_reset repress: got %h expected %h", obs(0), e); end
   endtask

   initial begin
      test_reset();
      test_step_left();
      test_both();
      test_held_key();
      test_win_right();
      test_match_end();
      test_reset_held_key();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
